jt10_acc_seq: RTL and testbench

JT10_ACC_SEQ -- requirements
Module: jt10_acc_seq

---
 rtl/jt12_pkg.sv | 56 +++++
 rtl/jt10_adpcm_hold.sv | 87 ++++++++
 rtl/jt10_acc_seq.sv | 126 ++++++++++++
 tb/tb_jt10_acc_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_pkg.sv
// Shared slot constants and slot decoding for the jt10/jt12 accumulator sequencer.
package jt12_pkg;

    // One sound round is 6 channels x 4 operators.
    localparam int         SLOT_NUM  = 24;
    localparam int         CH_PER_OP = 6;
    localparam logic [4:0] SLOT_LAST = 5'(SLOT_NUM - 1);

    // Channel map: slot%6 = 0,1,2,3,4,5 -> channel 0,1,2,4,5,6 (3 and 7 are never used).
    // Packed as six 3-bit entries, entry 0 in the least significant bits.
    localparam logic [17:0] CH_MAP = {3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};

    // Everything the accumulator needs to know about the current slot.
    typedef struct packed {
        logic [2:0] ch;
        logic [1:0] op;
        logic       s1;
        logic       s2;
        logic       s3;
        logic       s4;
        logic       zero;
    } slot_dec_t;

    // Decode of slot 0, used as the reset value of the registered slot outputs.
    localparam slot_dec_t SLOT_DEC_RST = '{
        ch: 3'd0, op: 2'd0, s1: 1'b1, s2: 1'b0, s3: 1'b0, s4: 1'b0, zero: 1'b1
    };

    // Map a slot number 0..23 onto channel, operator, operator-enter strobes and zero.
    function automatic slot_dec_t decode_slot(input logic [4:0] slot);
        slot_dec_t  d;
        logic [4:0] rem;
        int         idx;
        d = '0;
        if (slot < 5'd6) begin
            d.op = 2'd0;
        end else if (slot < 5'd12) begin
            d.op = 2'd1;
        end else if (slot < 5'd18) begin
            d.op = 2'd2;
        end else begin
            d.op = 2'd3;
        end
        rem    = slot - 5'(CH_PER_OP) * {3'b000, d.op};
        idx    = 3 * int'(rem);
        d.ch   = CH_MAP[idx +: 3];
        // Operator order in the accumulator is S1, S3, S2, S4.
        d.s1   = (d.op == 2'd0);
        d.s3   = (d.op == 2'd1);
        d.s2   = (d.op == 2'd2);
        d.s4   = (d.op == 2'd3);
        d.zero = (slot == 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/jt10_adpcm_hold.sv
// One-entry pending buffer for an ADPCM stereo sample, handed to the accumulator
// only at round boundaries, with a sticky underrun flag.
//
// Handshake: a sample transfers on any clk where valid_i && ready_o; ready_o is
// high exactly while the pending entry is empty and does not depend on valid_i.
module jt10_adpcm_hold
    import jt12_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] l_i,
    input  logic [DW-1:0] r_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          boundary_i,
    input  logic          underrun_clr_i,
    output logic [DW-1:0] l_o,
    output logic [DW-1:0] r_o,
    output logic          underrun_o
);

    logic [DW-1:0] pend_l_q, pend_l_d;
    logic [DW-1:0] pend_r_q, pend_r_d;
    logic          pend_full_q, pend_full_d;
    logic [DW-1:0] out_l_q, out_l_d;
    logic [DW-1:0] out_r_q, out_r_d;
    logic          underrun_q, underrun_d;
    logic          load;

    assign ready_o    = ~pend_full_q;
    assign l_o        = out_l_q;
    assign r_o        = out_r_q;
    assign underrun_o = underrun_q;

    // Next state: accept into pending, promote pending at a boundary, track underruns.
    always_comb begin
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        pend_full_d = pend_full_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        underrun_d  = underrun_q;
        load        = valid_i && !pend_full_q;

        if (boundary_i && pend_full_q) begin
            out_l_d     = pend_l_q;
            out_r_d     = pend_r_q;
            pend_full_d = 1'b0;
        end
        // A load only happens with pending empty, so it never collides with the
        // promotion above; at an empty boundary the new sample waits for the next round.
        if (load) begin
            pend_l_d    = l_i;
            pend_r_d    = r_i;
            pend_full_d = 1'b1;
        end
        if (underrun_clr_i) begin
            underrun_d = 1'b0;
        end
        // Setting is evaluated last so it wins over a simultaneous clear.
        if (boundary_i && !pend_full_q) begin
            underrun_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            pend_full_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            pend_full_q <= pend_full_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: rtl/jt10_acc_seq.sv
// Slot sequencer for the jt10 accumulator: walks the 24 slots of a round, drives
// channel/operator selects, holds ADPCM samples stable per round and captures the mix.
// clk_en is expected to be a divided enable; the registered slot outputs trail the
// counter by one clk, so zero spans exactly one clk_en period per round.
module jt10_acc_seq
    import jt12_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          run,
    input  logic [DW-1:0] adpcmA_l,
    input  logic [DW-1:0] adpcmA_r,
    input  logic          adpcmA_valid,
    output logic          adpcmA_ready,
    input  logic [DW-1:0] adpcmB_l,
    input  logic [DW-1:0] adpcmB_r,
    input  logic          adpcmB_valid,
    output logic          adpcmB_ready,
    output logic [2:0]    cur_ch,
    output logic [1:0]    cur_op,
    output logic          s1_enters,
    output logic          s2_enters,
    output logic          s3_enters,
    output logic          s4_enters,
    output logic          zero,
    output logic [DW-1:0] adpcmA_l_q,
    output logic [DW-1:0] adpcmA_r_q,
    output logic [DW-1:0] adpcmB_l_q,
    output logic [DW-1:0] adpcmB_r_q,
    input  logic [DW-1:0] acc_left,
    input  logic [DW-1:0] acc_right,
    output logic [DW-1:0] left,
    output logic [DW-1:0] right,
    output logic          sample,
    output logic          underrun_a,
    output logic          underrun_b,
    input  logic          underrun_clr
);

    logic [4:0]    slot_q, slot_d;
    slot_dec_t     dec_q, dec_d;
    logic [DW-1:0] left_q, left_d;
    logic [DW-1:0] right_q, right_d;
    logic          sample_q, sample_d;
    logic          advance;
    logic          boundary;

    assign advance  = clk_en && run;
    assign boundary = advance && dec_q.zero;

    assign cur_ch    = dec_q.ch;
    assign cur_op    = dec_q.op;
    assign s1_enters = dec_q.s1;
    assign s2_enters = dec_q.s2;
    assign s3_enters = dec_q.s3;
    assign s4_enters = dec_q.s4;
    assign zero      = dec_q.zero;
    assign left      = left_q;
    assign right     = right_q;
    assign sample    = sample_q;

    // Next state: slot counter with wrap, one-clk-late slot decode, mix capture.
    always_comb begin
        slot_d   = slot_q;
        dec_d    = decode_slot(slot_q);
        left_d   = left_q;
        right_d  = right_q;
        sample_d = boundary;
        if (advance) begin
            slot_d = (slot_q == SLOT_LAST) ? 5'd0 : slot_q + 5'd1;
        end
        if (boundary) begin
            left_d  = acc_left;
            right_d = acc_right;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q   <= 5'd0;
            dec_q    <= SLOT_DEC_RST;
            left_q   <= '0;
            right_q  <= '0;
            sample_q <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            dec_q    <= dec_d;
            left_q   <= left_d;
            right_q  <= right_d;
            sample_q <= sample_d;
        end
    end

    jt10_adpcm_hold #(.DW(DW)) u_hold_a (
        .clk            (clk),
        .rst            (rst),
        .l_i            (adpcmA_l),
        .r_i            (adpcmA_r),
        .valid_i        (adpcmA_valid),
        .ready_o        (adpcmA_ready),
        .boundary_i     (boundary),
        .underrun_clr_i (underrun_clr),
        .l_o            (adpcmA_l_q),
        .r_o            (adpcmA_r_q),
        .underrun_o     (underrun_a)
    );

    jt10_adpcm_hold #(.DW(DW)) u_hold_b (
        .clk            (clk),
        .rst            (rst),
        .l_i            (adpcmB_l),
        .r_i            (adpcmB_r),
        .valid_i        (adpcmB_valid),
        .ready_o        (adpcmB_ready),
        .boundary_i     (boundary),
        .underrun_clr_i (underrun_clr),
        .l_o            (adpcmB_l_q),
        .r_o            (adpcmB_r_q),
        .underrun_o     (underrun_b)
    );

endmodule

// File: tb/tb_jt10_acc_seq.sv
// Directed bench for jt10_acc_seq: slot walk, ADPCM hand-off, underrun, mix capture,
// run freeze and asynchronous reset.
module tb_jt10_acc_seq;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic          run;
    logic [DW-1:0] adpcmA_l, adpcmA_r, adpcmB_l, adpcmB_r;
    logic          adpcmA_valid, adpcmB_valid;
    logic          adpcmA_ready, adpcmB_ready;
    logic [2:0]    cur_ch;
    logic [1:0]    cur_op;
    logic          s1_enters, s2_enters, s3_enters, s4_enters;
    logic          zero;
    logic [DW-1:0] adpcmA_l_q, adpcmA_r_q, adpcmB_l_q, adpcmB_r_q;
    logic [DW-1:0] acc_left, acc_right;
    logic [DW-1:0] left, right;
    logic          sample;
    logic          underrun_a, underrun_b;
    logic          underrun_clr;

    int n_asserts = 0;
    int n_fails   = 0;
    int m_slot    = 0;
    int ch_tbl [6] = '{0, 1, 2, 4, 5, 6};
    int s_tbl  [4] = '{1, 4, 2, 8};   // {s4,s3,s2,s1} for op 0..3

    jt10_acc_seq #(.DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .run          (run),
        .adpcmA_l     (adpcmA_l),
        .adpcmA_r     (adpcmA_r),
        .adpcmA_valid (adpcmA_valid),
        .adpcmA_ready (adpcmA_ready),
        .adpcmB_l     (adpcmB_l),
        .adpcmB_r     (adpcmB_r),
        .adpcmB_valid (adpcmB_valid),
        .adpcmB_ready (adpcmB_ready),
        .cur_ch       (cur_ch),
        .cur_op       (cur_op),
        .s1_enters    (s1_enters),
        .s2_enters    (s2_enters),
        .s3_enters    (s3_enters),
        .s4_enters    (s4_enters),
        .zero         (zero),
        .adpcmA_l_q   (adpcmA_l_q),
        .adpcmA_r_q   (adpcmA_r_q),
        .adpcmB_l_q   (adpcmB_l_q),
        .adpcmB_r_q   (adpcmB_r_q),
        .acc_left     (acc_left),
        .acc_right    (acc_right),
        .left         (left),
        .right        (right),
        .sample       (sample),
        .underrun_a   (underrun_a),
        .underrun_b   (underrun_b),
        .underrun_clr (underrun_clr)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slot outputs against the model slot number.
    task automatic chk_slot();
        chk($sformatf("cur_ch@%0d", m_slot), 32'(cur_ch), 32'(ch_tbl[m_slot % 6]));
        chk($sformatf("cur_op@%0d", m_slot), 32'(cur_op), 32'(m_slot / 6));
        chk($sformatf("s_enters@%0d", m_slot),
            32'({s4_enters, s3_enters, s2_enters, s1_enters}), 32'(s_tbl[m_slot / 6]));
        chk($sformatf("zero@%0d", m_slot), 32'(zero), 32'(m_slot == 0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".cur_ch"}, 32'(cur_ch), 32'd0);
        chk({tag, ".cur_op"}, 32'(cur_op), 32'd0);
        chk({tag, ".s_enters"}, 32'({s4_enters, s3_enters, s2_enters, s1_enters}), 32'h1);
        chk({tag, ".zero"}, 32'(zero), 32'd1);
        chk({tag, ".readyA"}, 32'(adpcmA_ready), 32'd1);
        chk({tag, ".readyB"}, 32'(adpcmB_ready), 32'd1);
        chk({tag, ".Aq"}, 32'({adpcmA_l_q, adpcmA_r_q}), 32'd0);
        chk({tag, ".Bq"}, 32'({adpcmB_l_q, adpcmB_r_q}), 32'd0);
        chk({tag, ".mix"}, 32'({left, right}), 32'd0);
        chk({tag, ".sample"}, 32'(sample), 32'd0);
        chk({tag, ".underrun"}, 32'({underrun_a, underrun_b}), 32'd0);
    endtask

    // One clk_en pulse with run high; returns once the slot outputs reflect it.
    task automatic en_pulse();
        @(negedge clk) clk_en = 1'b1;
        @(negedge clk) clk_en = 1'b0;
        m_slot = (m_slot + 1) % 24;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;  clk_en = 1'b0;  run = 1'b1;
        adpcmA_l = '0;  adpcmA_r = '0;  adpcmA_valid = 1'b0;
        adpcmB_l = '0;  adpcmB_r = '0;  adpcmB_valid = 1'b0;
        acc_left = '0;  acc_right = '0;  underrun_clr = 1'b0;

        // Reset state.
        #12;
        chk_reset_state("rst");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Two full rounds of slot sequencing.
        for (int i = 0; i < 48; i++) begin
            chk_slot();
            en_pulse();
        end
        chk_slot();
        // Both rounds started with nothing pending.
        chk("walk.underrun_a", 32'(underrun_a), 32'd1);
        chk("walk.underrun_b", 32'(underrun_b), 32'd1);
        @(negedge clk) underrun_clr = 1'b1;
        @(negedge clk) underrun_clr = 1'b0;
        chk("clr.underrun", 32'({underrun_a, underrun_b}), 32'd0);

        // A sample accepted mid-round; only A is supplied.
        @(negedge clk) begin
            adpcmA_l = 16'h1234;  adpcmA_r = 16'hABCD;  adpcmA_valid = 1'b1;
        end
        @(negedge clk) adpcmA_valid = 1'b0;
        chk("load.readyA", 32'(adpcmA_ready), 32'd0);
        chk("load.Alq_held", 32'(adpcmA_l_q), 32'd0);
        acc_left = 16'h7FFF;  acc_right = 16'h8000;

        // Boundary: hand-off, mix capture, B underrun.
        @(negedge clk) clk_en = 1'b1;
        @(posedge clk) #1;
        chk("bnd.sample", 32'(sample), 32'd1);
        chk("bnd.left", 32'(left), 32'h7FFF);
        chk("bnd.right", 32'(right), 32'h8000);
        chk("bnd.Alq", 32'(adpcmA_l_q), 32'h1234);
        chk("bnd.Arq", 32'(adpcmA_r_q), 32'hABCD);
        chk("bnd.readyA", 32'(adpcmA_ready), 32'd1);
        chk("bnd.underrun_a", 32'(underrun_a), 32'd0);
        chk("bnd.underrun_b", 32'(underrun_b), 32'd1);
        @(negedge clk) clk_en = 1'b0;
        m_slot = 1;
        @(posedge clk) #1;
        chk("bnd.sample_width", 32'(sample), 32'd0);
        chk("bnd.left_held", 32'(left), 32'h7FFF);
        @(negedge clk);
        chk_slot();
        @(negedge clk) underrun_clr = 1'b1;
        @(negedge clk) underrun_clr = 1'b0;
        chk("clr2.underrun_b", 32'(underrun_b), 32'd0);

        // B load coincident with a boundary while empty, clear also asserted.
        for (int i = 0; i < 23; i++) en_pulse();
        chk_slot();
        @(negedge clk) begin
            adpcmB_l = 16'h1111;  adpcmB_r = 16'h2222;  adpcmB_valid = 1'b1;
            clk_en = 1'b1;  underrun_clr = 1'b1;  acc_left = 16'h0042;
        end
        @(posedge clk) #1;
        chk("coinc.Blq", 32'(adpcmB_l_q), 32'd0);
        chk("coinc.Brq", 32'(adpcmB_r_q), 32'd0);
        chk("coinc.readyB", 32'(adpcmB_ready), 32'd0);
        chk("coinc.underrun_b", 32'(underrun_b), 32'd1);
        chk("coinc.underrun_a", 32'(underrun_a), 32'd1);
        chk("coinc.left", 32'(left), 32'h0042);
        @(negedge clk) begin
            adpcmB_valid = 1'b0;  clk_en = 1'b0;  underrun_clr = 1'b0;
        end
        m_slot = 1;
        @(negedge clk);
        chk_slot();

        // run low at slot 0: no boundary, no advance, handshake still accepts.
        for (int i = 0; i < 23; i++) en_pulse();
        run = 1'b0;
        @(negedge clk) begin
            adpcmA_l = 16'h5678;  adpcmA_valid = 1'b1;  clk_en = 1'b1;
        end
        @(posedge clk) #1;
        chk("frz.sample", 32'(sample), 32'd0);
        chk("frz.readyA", 32'(adpcmA_ready), 32'd0);
        chk("frz.Alq", 32'(adpcmA_l_q), 32'h1234);
        @(negedge clk) begin
            adpcmA_valid = 1'b0;  clk_en = 1'b1;
        end
        @(negedge clk) clk_en = 1'b0;
        @(negedge clk);
        chk_slot();
        run = 1'b1;

        // Next boundary delivers both pending samples.
        @(negedge clk) clk_en = 1'b1;
        @(posedge clk) #1;
        chk("bnd3.sample", 32'(sample), 32'd1);
        chk("bnd3.Aq", 32'({adpcmA_l_q, adpcmA_r_q}), 32'h5678ABCD);
        chk("bnd3.Bq", 32'({adpcmB_l_q, adpcmB_r_q}), 32'h11112222);
        chk("bnd3.ready", 32'({adpcmA_ready, adpcmB_ready}), 32'h3);
        @(negedge clk) clk_en = 1'b0;
        m_slot = 1;
        @(negedge clk);
        chk_slot();

        // Asynchronous reset at slot 13, away from any clock edge.
        for (int i = 0; i < 12; i++) en_pulse();
        chk_slot();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_state("arst");
        @(negedge clk) rst = 1'b0;
        m_slot = 0;
        @(negedge clk);
        chk_slot();
        // First enable after reset is a boundary.
        @(negedge clk) clk_en = 1'b1;
        @(posedge clk) #1;
        chk("post_rst.sample", 32'(sample), 32'd1);
        @(negedge clk) clk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
